// File: rtl/clock_step_pkg.sv
// Shared definitions for the CPU clock-step controller.
//
// Contents:
//   state_t             - 2-bit control FSM encoding (PAUSE/RUN/STEP/HALTED)
//   DEB_CYCLES_DEFAULT  - default button debounce interval in clk_in cycles
package clock_step_pkg;

  typedef enum logic [1:0] {
    PAUSE  = 2'd0,
    RUN    = 2'd1,
    STEP   = 2'd2,
    HALTED = 2'd3
  } state_t;

  localparam logic [19:0] DEB_CYCLES_DEFAULT = 20'd500000;

endpackage

// File: rtl/btn_debounce.sv
// Button debouncer: the output level follows the raw input only after the raw
// input has disagreed with the current level for DEB_CYCLES consecutive
// cycles. A one-cycle press pulse accompanies every 0->1 level change.
//
// Ports:
//   clk_in  in   system clock
//   rst_n   in   asynchronous active-low reset
//   raw     in   raw (bouncy) button input
//   level   out  debounced level
//   press   out  one-cycle pulse on debounced rising edge
module btn_debounce
  import clock_step_pkg::*;
#(
  parameter int                DEB_W      = 20,
  parameter logic [DEB_W-1:0]  DEB_CYCLES = DEB_W'(DEB_CYCLES_DEFAULT)
) (
  input  logic clk_in,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic press
);

  logic [DEB_W-1:0] cnt_reg;
  logic             level_reg;
  logic             press_reg;

  // The counter only runs while raw disagrees with the level; any return to
  // agreement (a bounce) restarts the interval from zero.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg   <= '0;
      level_reg <= 1'b0;
      press_reg <= 1'b0;
    end else begin
      press_reg <= 1'b0;
      if (raw == level_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == DEB_CYCLES - DEB_W'(1)) begin
        cnt_reg   <= '0;
        level_reg <= raw;
        press_reg <= raw;
      end else begin
        cnt_reg <= cnt_reg + DEB_W'(1);
      end
    end
  end

  assign level = level_reg;
  assign press = press_reg;

endmodule

// File: rtl/clock_step_ctrl.sv
// CPU clock-step controller. Converts rising edges of the divided tick into
// single-cycle CPU clock enables, under a run/pause/single-step/halt FSM
// driven by debounced buttons. Also owns the divider speed select.
//
// Ports:
//   clk_in     in   system clock
//   rst_n      in   asynchronous active-low reset
//   tick_in    in   divided clock (synchronous to clk_in)
//   btn_run    in   raw button: toggle run/pause
//   btn_step   in   raw button: single step while paused
//   btn_speed  in   raw button: toggle divider speed
//   cpu_halt   in   CPU executed a halt instruction
//   cpu_ce     out  one-cycle CPU clock enable
//   fast_sel   out  divider speed select, 1 = fast
//   run_led    out  high while in RUN
//   state_o    out  current FSM state
//   step_cnt   out  count of cpu_ce pulses (only with CLOCK_STEP_CTRL_STEP_COUNT_EN)
//
// Optional feature macro: CLOCK_STEP_CTRL_STEP_COUNT_EN
module clock_step_ctrl
  import clock_step_pkg::*;
#(
  parameter int               DEB_W      = 20,
  parameter logic [DEB_W-1:0] DEB_CYCLES = DEB_W'(DEB_CYCLES_DEFAULT)
) (
  input  logic        clk_in,
  input  logic        rst_n,
  input  logic        tick_in,
  input  logic        btn_run,
  input  logic        btn_step,
  input  logic        btn_speed,
  input  logic        cpu_halt,
  output logic        cpu_ce,
  output logic        fast_sel,
  output logic        run_led,
  output logic [1:0]  state_o
`ifdef CLOCK_STEP_CTRL_STEP_COUNT_EN
  ,
  output logic [15:0] step_cnt
`endif
);

  // Button index order: 0 = run, 1 = step, 2 = speed.
  logic [2:0] raw_vec;
  logic [2:0] level_unused;
  logic [2:0] press_vec;

  assign raw_vec = {btn_speed, btn_step, btn_run};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_deb
      btn_debounce #(
        .DEB_W      (DEB_W),
        .DEB_CYCLES (DEB_CYCLES)
      ) u_deb (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .raw    (raw_vec[gi]),
        .level  (level_unused[gi]),
        .press  (press_vec[gi])
      );
    end
  endgenerate

  logic   run_press;
  logic   step_press;
  logic   speed_press;
  logic   tick_d_reg;
  logic   tick_rise;
  state_t state_reg;
  state_t state_next;
  logic   cpu_ce_reg;
  logic   cpu_ce_next;
  logic   fast_sel_reg;

  assign run_press   = press_vec[0];
  assign step_press  = press_vec[1];
  assign speed_press = press_vec[2];

  // A tick held high for many cycles yields a single rise.
  assign tick_rise = tick_in & ~tick_d_reg;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      tick_d_reg   <= 1'b0;
      state_reg    <= PAUSE;
      cpu_ce_reg   <= 1'b0;
      fast_sel_reg <= 1'b0;
    end else begin
      tick_d_reg <= tick_in;
      state_reg  <= state_next;
      cpu_ce_reg <= cpu_ce_next;
      if (speed_press) begin
        fast_sel_reg <= ~fast_sel_reg;
      end
    end
  end

  // Halt overrides every other input, including a tick in the same cycle.
  // Run wins over step when both are pressed together in PAUSE.
  always_comb begin
    state_next  = state_reg;
    cpu_ce_next = 1'b0;
    if (cpu_halt) begin
      state_next = HALTED;
    end else begin
      case (state_reg)
        PAUSE: begin
          if (run_press) begin
            state_next = RUN;
          end else if (step_press) begin
            state_next = STEP;
          end
        end
        RUN: begin
          // A pause press on a tick cycle still lets that tick through.
          cpu_ce_next = tick_rise;
          if (run_press) begin
            state_next = PAUSE;
          end
        end
        STEP: begin
          if (tick_rise) begin
            cpu_ce_next = 1'b1;
            state_next  = PAUSE;
          end
        end
        HALTED: begin
          state_next = HALTED;
        end
        default: begin
          state_next = PAUSE;
        end
      endcase
    end
  end

  assign cpu_ce   = cpu_ce_reg;
  assign fast_sel = fast_sel_reg;
  assign run_led  = (state_reg == RUN);
  assign state_o  = state_reg;

`ifdef CLOCK_STEP_CTRL_STEP_COUNT_EN
  logic [15:0] step_cnt_reg;

  // cpu_ce is never high in HALTED, so the count freezes there naturally;
  // the explicit state test keeps that intent visible.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      step_cnt_reg <= 16'd0;
    end else if (cpu_ce_reg && (state_reg != HALTED)) begin
      step_cnt_reg <= step_cnt_reg + 16'd1;
    end
  end

  assign step_cnt = step_cnt_reg;
`endif

endmodule

// File: tb/tb_clock_step_ctrl.sv
module tb_clock_step_ctrl;

  logic        clk_in;
  logic        rst_n;
  logic        tick_in;
  logic        btn_run;
  logic        btn_step;
  logic        btn_speed;
  logic        cpu_halt;
  logic        cpu_ce;
  logic        fast_sel;
  logic        run_led;
  logic [1:0]  state_o;
`ifdef CLOCK_STEP_CTRL_STEP_COUNT_EN
  logic [15:0] step_cnt;
`endif

  clock_step_ctrl #(
    .DEB_W      (20),
    .DEB_CYCLES (20'd4)
  ) dut (
    .clk_in    (clk_in),
    .rst_n     (rst_n),
    .tick_in   (tick_in),
    .btn_run   (btn_run),
    .btn_step  (btn_step),
    .btn_speed (btn_speed),
    .cpu_halt  (cpu_halt),
    .cpu_ce    (cpu_ce),
    .fast_sel  (fast_sel),
    .run_led   (run_led),
    .state_o   (state_o)
`ifdef CLOCK_STEP_CTRL_STEP_COUNT_EN
    ,
    .step_cnt  (step_cnt)
`endif
  );

  localparam int B_NONE  = 0;
  localparam int B_RUN   = 1;
  localparam int B_STEP  = 2;
  localparam int B_SPEED = 3;

  typedef struct {
    string name;
    int    btn;
    int    n_ticks;
    int    exp_state;
    int    exp_ce;
    int    exp_fast;
  } vec_t;

  vec_t vecs [8];

  int n_cmp;
  int n_fail;
  int ce_total;
  int bad_align;
  int ce0;
  bit t1;
  bit t2;

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  // Count every cpu_ce pulse and verify it lands in the cycle right after
  // the first cycle in which tick_in reads high.
  initial begin
    ce_total  = 0;
    bad_align = 0;
    t1 = 1'b0;
    t2 = 1'b0;
    forever begin
      @(negedge clk_in);
      if (cpu_ce) begin
        ce_total++;
        if (!(t1 && !t2)) bad_align++;
      end
      t2 = t1;
      t1 = tick_in;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  task automatic set_btn(input int b, input logic v);
    case (b)
      B_RUN:   btn_run   = v;
      B_STEP:  btn_step  = v;
      B_SPEED: btn_speed = v;
      default: ;
    endcase
  endtask

  task automatic press(input int b);
    if (b != B_NONE) begin
      set_btn(b, 1'b1);
      cyc(6);
      set_btn(b, 1'b0);
      cyc(6);
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      tick_in = 1'b1;
      cyc(5);
      tick_in = 1'b0;
      cyc(5);
    end
  endtask

  initial begin
    n_cmp     = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    tick_in   = 1'b0;
    btn_run   = 1'b0;
    btn_step  = 1'b0;
    btn_speed = 1'b0;
    cpu_halt  = 1'b0;

    vecs[0] = '{"idle_pause",   B_NONE,  5,  0, 0,  0};
    vecs[1] = '{"run_10_ticks", B_RUN,   10, 1, 10, 0};
    vecs[2] = '{"speed_in_run", B_SPEED, 3,  1, 3,  1};
    vecs[3] = '{"pause",        B_RUN,   3,  0, 0,  1};
    vecs[4] = '{"single_step",  B_STEP,  3,  0, 1,  1};
    vecs[5] = '{"speed_pause",  B_SPEED, 2,  0, 0,  0};
    vecs[6] = '{"run_again",    B_RUN,   4,  1, 4,  0};
    vecs[7] = '{"pause_again",  B_RUN,   0,  0, 0,  0};

    // Reset state
    cyc(3);
    check("reset_state", int'(state_o), 0);
    check("reset_cpu_ce", int'(cpu_ce), 0);
    check("reset_fast_sel", int'(fast_sel), 0);
    check("reset_run_led", int'(run_led), 0);
    rst_n = 1'b1;
    cyc(2);

    // Table-driven sequences
    for (int i = 0; i < 8; i++) begin
      ce0 = ce_total;
      press(vecs[i].btn);
      ticks(vecs[i].n_ticks);
      check({vecs[i].name, "_state"}, int'(state_o), vecs[i].exp_state);
      check({vecs[i].name, "_ce"}, ce_total - ce0, vecs[i].exp_ce);
      check({vecs[i].name, "_fast"}, int'(fast_sel), vecs[i].exp_fast);
      check({vecs[i].name, "_led"}, int'(run_led), (vecs[i].exp_state == 1) ? 1 : 0);
    end

    // Second step press while still waiting in STEP is ignored
    ce0 = ce_total;
    press(B_STEP);
    check("step_wait_state", int'(state_o), 2);
    cyc(3);
    press(B_STEP);
    ticks(2);
    check("double_step_ce", ce_total - ce0, 1);
    check("double_step_state", int'(state_o), 0);

    // Pause press coinciding with a tick rise still emits that cpu_ce
    press(B_RUN);
    ce0 = ce_total;
    btn_run = 1'b1;
    cyc(4);
    tick_in = 1'b1;
    cyc(1);
    check("pause_on_tick_state", int'(state_o), 0);
    check("pause_on_tick_ce_now", int'(cpu_ce), 1);
    cyc(4);
    tick_in = 1'b0;
    btn_run = 1'b0;
    cyc(6);
    check("pause_on_tick_ce_count", ce_total - ce0, 1);

    // Halt beats a simultaneous run press and tick rise
    press(B_RUN);
    check("pre_halt_state", int'(state_o), 1);
    ce0 = ce_total;
    btn_run = 1'b1;
    cyc(4);
    cpu_halt = 1'b1;
    tick_in = 1'b1;
    cyc(1);
    check("halt_state", int'(state_o), 3);
    check("halt_cpu_ce", int'(cpu_ce), 0);
    cpu_halt = 1'b0;
    cyc(4);
    tick_in = 1'b0;
    btn_run = 1'b0;
    cyc(6);
    ticks(10);
    check("halt_no_ce", ce_total - ce0, 0);
    press(B_RUN);
    check("halt_ignores_run", int'(state_o), 3);
    check("halt_run_led", int'(run_led), 0);
    press(B_SPEED);
    check("halt_speed_toggles", int'(fast_sel), 1);
`ifdef CLOCK_STEP_CTRL_STEP_COUNT_EN
    check("halt_step_cnt_holds", int'(step_cnt), ce_total);
`endif

    rst_n = 1'b0;
    cyc(2);
    check("rst2_state", int'(state_o), 0);
    check("rst2_fast_sel", int'(fast_sel), 0);
`ifdef CLOCK_STEP_CTRL_STEP_COUNT_EN
    check("rst2_step_cnt", int'(step_cnt), 0);
`endif
    rst_n = 1'b1;
    cyc(2);

    // Bouncing speed button: 2 high, 2 low, then stable -> one toggle
    btn_speed = 1'b1; cyc(2);
    btn_speed = 1'b0; cyc(2);
    btn_speed = 1'b1; cyc(6);
    btn_speed = 1'b0; cyc(8);
    check("bounce_one_toggle", int'(fast_sel), 1);
    // Held 3 cycles (one short of the interval): no press
    btn_speed = 1'b1; cyc(3);
    btn_speed = 1'b0; cyc(8);
    check("short_glitch_ignored", int'(fast_sel), 1);
    // Held exactly 4 cycles: press
    btn_speed = 1'b1; cyc(4);
    btn_speed = 1'b0; cyc(8);
    check("exact_interval_press", int'(fast_sel), 0);

    // Reset during an in-flight cpu_ce
    press(B_RUN);
    ticks(3);
`ifdef CLOCK_STEP_CTRL_STEP_COUNT_EN
    check("step_cnt_three", int'(step_cnt), 3);
`endif
    tick_in = 1'b1;
    cyc(1);
    check("inflight_ce_high", int'(cpu_ce), 1);
    rst_n = 1'b0;
    #1;
    check("rst_drops_ce", int'(cpu_ce), 0);
    check("rst_mid_state", int'(state_o), 0);
    check("rst_mid_led", int'(run_led), 0);
`ifdef CLOCK_STEP_CTRL_STEP_COUNT_EN
    check("rst_mid_step_cnt", int'(step_cnt), 0);
`endif
    tick_in = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(2);

    check("ce_alignment_errors", bad_align, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
